// File: rtl/alu_seq_unit_if.sv
// Handshake and operand/result bundle between the BRISC controller and the
// sequential execute stage.
interface alu_seq_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_data;
  logic [WIDTH-1:0] b_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;

  modport master (
    output start, op, a_data, b_data,
    input  busy, done, result, flag_z, flag_n, flag_c
  );

  modport slave (
    input  start, op, a_data, b_data,
    output busy, done, result, flag_z, flag_n, flag_c
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Sequential execute stage: single-cycle logic/add ops, iterative shifts
// (one bit per cycle) and a 16-step shift-add unsigned multiplier.
module alu_seq_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  alu_seq_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, ITER, COMPLETE} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL
  } op_t;

  state_t             state_q, state_d;
  op_t                op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] mcand_q, acc_q;
  logic               sh_c_q;

  logic               done_q, z_q, n_q, c_q;
  logic [WIDTH-1:0]   result_q;

  logic               accept, finish, c_d;
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH:0]     sum;
  logic               iter_op;

  assign accept  = bus.start && (state_q == IDLE || state_q == COMPLETE);
  assign iter_op = (bus.op == OP_MUL) ||
                   ((bus.op == OP_SHL || bus.op == OP_SHR) && bus.b_data[3:0] != 4'd0);
  assign sum     = {1'b0, a_q} + {1'b0, b_q};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; COMPLETE doubles as an idle cycle so back-to-back issue works
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      IDLE, COMPLETE: begin
        state_d = IDLE;
        if (accept) state_d = iter_op ? ITER : EXEC;
      end
      EXEC: begin
        state_d = COMPLETE;
        finish  = 1'b1;
      end
      ITER: begin
        if (cnt_q == '0) begin
          state_d = COMPLETE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result and carry selected at the completing edge
  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    if (state_q == ITER) begin
      if (op_q == OP_MUL) begin
        res_d = acc_q[WIDTH-1:0];
        c_d   = |acc_q[2*WIDTH-1:WIDTH];
      end else begin
        res_d = a_q;
        c_d   = sh_c_q;
      end
    end else begin
      case (op_q)
        OP_ADD: begin
          res_d = sum[WIDTH-1:0];
          c_d   = sum[WIDTH];
        end
        OP_SUB: begin
          res_d = a_q - b_q;
          c_d   = (a_q < b_q);
        end
        OP_AND:  res_d = a_q & b_q;
        OP_OR:   res_d = a_q | b_q;
        OP_XOR:  res_d = a_q ^ b_q;
        default: res_d = a_q;  // zero-distance shift passes A through, C=0
      endcase
    end
  end

  // Operand latch, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_ADD;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      sh_c_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        result_q <= res_d;
        z_q      <= (res_d == '0);
        n_q      <= res_d[WIDTH-1];
        c_q      <= c_d;
      end
      if (accept) begin
        op_q    <= op_t'(bus.op);
        a_q     <= bus.a_data;
        b_q     <= bus.b_data;
        sh_c_q  <= 1'b0;
        acc_q   <= '0;
        mcand_q <= {{WIDTH{1'b0}}, bus.a_data};
        cnt_q   <= (bus.op == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(bus.b_data[3:0]);
      end else if (state_q == ITER && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
        case (op_q)
          OP_SHL: begin
            sh_c_q <= a_q[WIDTH-1];
            a_q    <= a_q << 1;
          end
          OP_SHR: begin
            sh_c_q <= a_q[0];
            a_q    <= a_q >> 1;
          end
          OP_MUL: begin
            // multiplier (B) consumed LSB-first while A is shifted up
            if (b_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q <= mcand_q << 1;
            b_q     <= b_q >> 1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy   = (state_q == EXEC) || (state_q == ITER);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag_z = z_q;
  assign bus.flag_n = n_q;
  assign bus.flag_c = c_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed vector table, randomized ops against an
// arithmetic reference model, and hand sequences for stall/back-to-back/reset.
module tb_alu_seq_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  alu_seq_unit_if #(.WIDTH(16)) bus ();

  alu_seq_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the whole operands
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic c, output int lat);
    int unsigned k;
    logic [16:0] s;
    logic [31:0] p;
    k   = b[3:0];
    r   = '0;
    c   = 1'b0;
    lat = 1;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a << k; if (k != 0) begin c = a[16-k]; lat = 1 + k; end end
      3'd6: begin r = a >> k; if (k != 0) begin c = a[k-1];  lat = 1 + k; end end
      default: begin p = 32'(a) * 32'(b); r = p[15:0]; c = |p[31:16]; lat = 17; end
    endcase
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic ec, input int elat);
    int n;
    bit got;
    bit busy_ok;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a_data = a; bus.b_data = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op = 3'($urandom); bus.a_data = 16'($urandom); bus.b_data = 16'($urandom);
    busy_ok = (bus.busy === 1'b1);
    got = 0;
    n = 1;
    while (n <= 40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        got = 1;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 0;
      n++;
    end
    chk({name, " done_seen"}, 32'(got), 32'd1);
    chk({name, " latency"}, 32'(n), 32'(elat));
    chk({name, " result"}, 32'(bus.result), 32'(er));
    chk({name, " flags"}, {29'd0, bus.flag_z, bus.flag_n, bus.flag_c},
        {29'd0, (er == 16'h0), er[15], ec});
    chk({name, " busy_while_running"}, 32'(busy_ok), 32'd1);
    chk({name, " busy_at_done"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    chk({name, " single_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int n;
    bit got;
    bit quiet;
    logic [2:0]  rop;
    logic [15:0] ra, rb, rr;
    logic        rc;
    int          rl;

    vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1};
    vecs[1]  = '{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1};
    vecs[2]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1};
    vecs[3]  = '{3'd5, 16'h00F0, 16'h12A4, 16'h0F00, 1'b0, 5};
    vecs[4]  = '{3'd6, 16'h0001, 16'h0001, 16'h0000, 1'b1, 2};
    vecs[5]  = '{3'd5, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1};
    vecs[6]  = '{3'd7, 16'h0123, 16'h0010, 16'h1230, 1'b0, 17};
    vecs[7]  = '{3'd7, 16'h8000, 16'h0002, 16'h0000, 1'b1, 17};
    vecs[8]  = '{3'd2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1};
    vecs[9]  = '{3'd3, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1};
    vecs[10] = '{3'd4, 16'hFFFF, 16'hAAAA, 16'h5555, 1'b0, 1};
    vecs[11] = '{3'd6, 16'h8001, 16'h000F, 16'h0001, 1'b0, 16};
    vecs[12] = '{3'd5, 16'h8001, 16'h0001, 16'h0002, 1'b1, 2};

    bus.start = 1'b0; bus.op = '0; bus.a_data = '0; bus.b_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {26'd0, bus.busy, bus.done, bus.flag_z, bus.flag_n, bus.flag_c, 1'b0},
        32'd0);
    chk("reset result", 32'(bus.result), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].c, vecs[i].lat);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      model(rop, ra, rb, rr, rc, rl);
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rr, rc, rl);
    end

    // MUL with an ADD start pulsed while busy, then back-to-back ADD from the done cycle
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd7; bus.a_data = 16'h0003; bus.b_data = 16'h0005;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0;
    repeat (3) begin @(posedge clk); #1; n++; end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a_data = 16'hFFFF; bus.b_data = 16'h0001;
    @(posedge clk); #1;
    n++;
    bus.start = 1'b0; bus.a_data = 16'h5A5A; bus.b_data = 16'hA5A5;
    got = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.done === 1'b1) begin got = 1; break; end
    end
    chk("stall done_seen", 32'(got), 32'd1);
    chk("stall latency", 32'(n), 32'd17);
    chk("stall result", 32'(bus.result), 32'h000F);
    bus.start = 1'b1; bus.op = 3'd0; bus.a_data = 16'h0002; bus.b_data = 16'h0003;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b accepted busy", 32'(bus.busy), 32'd1);
    chk("b2b no done at accept", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    chk("b2b done", 32'(bus.done), 32'd1);
    chk("b2b result", 32'(bus.result), 32'h0005);
    @(posedge clk); #1;
    chk("b2b single_done", 32'(bus.done), 32'd0);

    // Reset in the middle of a MUL, with nonzero result and flags beforehand
    run_op("pre-reset add", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1);
    run_op("pre-reset sub", 3'd1, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd7; bus.a_data = 16'h1234; bus.b_data = 16'h5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort result", 32'(bus.result), 32'd0);
    chk("abort flags", {29'd0, bus.flag_z, bus.flag_n, bus.flag_c}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet = 1;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 0;
    end
    chk("abort no done pulse", 32'(quiet), 32'd1);
    chk("abort result held", 32'(bus.result), 32'd0);
    run_op("post-reset mul", 3'd7, 16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
